rx_bytes_des: RTL and testbench



---
 rtl/rx_bytes_des.sv | 261 ++++++++++++++++++++++++++
 tb/tb_rx_bytes_des.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_bytes_des.sv
// rtl/rx_bytes_des.sv - UART-style receive deserializer feeding the rx ping-pong RAM
//
// Purpose:
//   Samples the asynchronous line rx, rebuilds 10-bit symbols (start 0,
//   8 data bits LSB first, stop 1) into bytes and writes them to the rx RAM.
//   Byte 2 of a frame carries data_len; a frame is data_len+5 bytes whose
//   last two bytes are a CRC-16 (low byte first) over the preceding bytes.
//   An idle-bit counter drives tx_permit and aborts stalled frames.
//   Byte 0 uses the low-speed bit period, later bytes the high-speed one.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   period_ls/period_hs clocks per bit minus 1 (low / high speed)
//   tx_permit_len       idle LS bits required before tx_permit
//   max_idle_len        idle LS bits that abort a partial frame
//   rx                  asynchronous line input
//   wr_addr/wr_data/wr_en  rx RAM write port (one-cycle strobe)
//   frame_done/crc_err/frame_err  one-cycle status pulses
//   tx_permit           level, bus idle long enough to transmit
//   bus_idle            level, receiver FSM in IDLE
//
// Build option:
//   RX_MAJORITY_EN      majority-of-three sampling around mid-bit
//                       (requires period >= 3); default is a single sample.

module serial_crc (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);
   // CRC-16/CCITT polynomial 0x1021, initial value 0, one bit per enable.
   logic fb;
   assign fb = din ^ crc[15];

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         crc <= 16'h0000;
      end else if (en) begin
         crc <= {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
   end
endmodule

module rx_bytes_des #(
   parameter int IDLE_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       period_ls,
   input  logic [15:0]       period_hs,
   input  logic [IDLE_W-1:0] tx_permit_len,
   input  logic [IDLE_W-1:0] max_idle_len,
   input  logic              rx,
   output logic [7:0]        wr_addr,
   output logic [7:0]        wr_data,
   output logic              wr_en,
   output logic              frame_done,
   output logic              crc_err,
   output logic              frame_err,
   output logic              tx_permit,
   output logic              bus_idle
);
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t state, state_nx;

   logic              rx_m, rx_s, rx_d;
   logic              fall;
   logic              hs_flag;
   logic [15:0]       period_cur, period_cnt, mid;
   logic              bit_inc, samp_pt, samp_val;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;
   logic [8:0]        byte_cnt;
   logic [7:0]        data_len, crc_lo;
   logic [15:0]       crc_out;
   logic              is_last, crc_feed, timeout, ctx_clear;
   logic              cmp_pend, cmp_ok, permit_q;
   logic [15:0]       idle_div;
   logic [IDLE_W-1:0] idle_cnt;
   logic              do_shift, do_write, do_stop_err, start_edge;

   // Line synchronizer; resets to the idle (mark) level so reset never
   // manufactures a falling edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   assign fall       = rx_d & ~rx_s;
   assign period_cur = hs_flag ? period_hs : period_ls;
   assign mid        = period_cur >> 1;
   assign bit_inc    = (period_cnt >= period_cur);

`ifdef RX_MAJORITY_EN
   // Decision is taken one clock after mid-bit so that rx_d2/rx_d/rx_s hold
   // the samples at mid-1, mid and mid+1.
   logic rx_d2;
   always_ff @(posedge clk) begin
      if (reset) rx_d2 <= 1'b1;
      else       rx_d2 <= rx_d;
   end
   assign samp_pt  = (state != S_IDLE) && (period_cnt == mid + 16'd1);
   assign samp_val = (rx_d2 & rx_d) | (rx_d2 & rx_s) | (rx_d & rx_s);
`else
   assign samp_pt  = (state != S_IDLE) && (period_cnt == mid);
   assign samp_val = rx_s;
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // FSM next state
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (fall) state_nx = S_START;
         S_START: if (samp_pt) state_nx = samp_val ? S_IDLE : S_DATA;
         S_DATA:  if (samp_pt && bit_idx == 3'd7) state_nx = S_STOP;
         S_STOP:  if (samp_pt) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      bus_idle    = 1'b0;
      start_edge  = 1'b0;
      do_shift    = 1'b0;
      do_write    = 1'b0;
      do_stop_err = 1'b0;
      unique case (state)
         S_IDLE: begin
            bus_idle   = 1'b1;
            start_edge = fall;
         end
         S_DATA:  do_shift    = samp_pt;
         S_STOP: begin
            do_write    = samp_pt & samp_val;
            do_stop_err = samp_pt & ~samp_val;
         end
         default: ;
      endcase
   end

   // Bit timing and shifting
   always_ff @(posedge clk) begin
      if (reset) begin
         period_cnt <= 16'd0;
         bit_idx    <= 3'd0;
         shreg      <= 8'd0;
      end else begin
         if (start_edge || state == S_IDLE || bit_inc) period_cnt <= 16'd0;
         else                                          period_cnt <= period_cnt + 16'd1;
         if (state == S_START)  bit_idx <= 3'd0;
         else if (do_shift)     bit_idx <= bit_idx + 3'd1;
         if (do_shift) shreg <= {samp_val, shreg[7:1]};
      end
   end

   // Frame context. data_len is meaningful only once byte 2 is written;
   // is_last cannot fire earlier because data_len+4 >= 4.
   assign is_last   = (byte_cnt == {1'b0, data_len} + 9'd4);
   assign crc_feed  = do_shift && ((byte_cnt < 9'd3) || (byte_cnt < {1'b0, data_len} + 9'd3));
   // A falling edge in the same cycle outranks the idle timeout.
   assign timeout   = bus_idle && (byte_cnt != 9'd0) && (idle_cnt == max_idle_len) && !fall;
   assign ctx_clear = do_stop_err | timeout | (do_write & is_last);

   serial_crc u_crc (
      .clk   (clk),
      .reset (reset),
      .clear (ctx_clear),
      .en    (crc_feed),
      .din   (samp_val),
      .crc   (crc_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         byte_cnt <= 9'd0;
         data_len <= 8'd0;
         crc_lo   <= 8'd0;
         hs_flag  <= 1'b0;
      end else if (ctx_clear) begin
         byte_cnt <= 9'd0;
         data_len <= 8'd0;
         hs_flag  <= 1'b0;
      end else if (do_write) begin
         byte_cnt <= byte_cnt + 9'd1;
         hs_flag  <= 1'b1;
         if (byte_cnt == 9'd2) data_len <= shreg;
         if (byte_cnt == {1'b0, data_len} + 9'd3) crc_lo <= shreg;
      end
   end

   // RAM port and status pulses; CRC verdict lands one cycle after the
   // final byte's write strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en      <= 1'b0;
         wr_addr    <= 8'd0;
         wr_data    <= 8'd0;
         cmp_pend   <= 1'b0;
         cmp_ok     <= 1'b0;
         frame_done <= 1'b0;
         crc_err    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         wr_en <= do_write;
         if (do_write) begin
            wr_addr <= byte_cnt[7:0];
            wr_data <= shreg;
         end
         cmp_pend   <= do_write & is_last;
         cmp_ok     <= ({shreg, crc_lo} == crc_out);
         frame_done <= cmp_pend & cmp_ok;
         crc_err    <= cmp_pend & ~cmp_ok;
         frame_err  <= do_stop_err | timeout;
      end
   end

   // Idle counter in LS bit periods, independent of the current bit speed.
   always_ff @(posedge clk) begin
      if (reset) begin
         idle_div <= 16'd0;
         idle_cnt <= '0;
         permit_q <= 1'b0;
      end else begin
         if (fall) begin
            idle_div <= 16'd0;
            idle_cnt <= '0;
         end else if (bus_idle && rx_s) begin
            if (idle_div >= period_ls) begin
               idle_div <= 16'd0;
               if (idle_cnt != '1) idle_cnt <= idle_cnt + 1'b1;
            end else begin
               idle_div <= idle_div + 16'd1;
            end
         end else begin
            idle_div <= 16'd0;
         end
         permit_q <= !fall && (idle_cnt >= tx_permit_len) && (byte_cnt == 9'd0);
      end
   end

   // Masking with fall drops the permit in the detection cycle itself.
   assign tx_permit = permit_q & ~fall;
endmodule

// File: tb/tb_rx_bytes_des.sv
// tb/tb_rx_bytes_des.sv - self-checking bench for rx_bytes_des
module tb_rx_bytes_des;
   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] period_ls, period_hs;
   logic [9:0]  tx_permit_len, max_idle_len;
   logic        rx;
   logic [7:0]  wr_addr, wr_data;
   logic        wr_en, frame_done, crc_err, frame_err, tx_permit, bus_idle;

   rx_bytes_des #(.IDLE_W(10)) dut (
      .clk(clk), .reset(reset), .period_ls(period_ls), .period_hs(period_hs),
      .tx_permit_len(tx_permit_len), .max_idle_len(max_idle_len), .rx(rx),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
      .frame_done(frame_done), .crc_err(crc_err), .frame_err(frame_err),
      .tx_permit(tx_permit), .bus_idle(bus_idle)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor
   logic [7:0] mon_addr[$];
   logic [7:0] mon_data[$];
   int         mon_cyc[$];
   int n_done, n_crc, n_ferr, n_rise;
   int done_cyc, crc_cyc, ferr_cyc, rise_cyc;
   logic permit_prev = 1'b0;

   always @(negedge clk) begin
      if (wr_en) begin
         mon_addr.push_back(wr_addr);
         mon_data.push_back(wr_data);
         mon_cyc.push_back(cyc);
      end
      if (frame_done) begin n_done++; done_cyc = cyc; end
      if (crc_err)    begin n_crc++;  crc_cyc  = cyc; end
      if (frame_err)  begin n_ferr++; ferr_cyc = cyc; end
      if (tx_permit && !permit_prev) begin n_rise++; rise_cyc = cyc; end
      permit_prev = tx_permit;
   end

   task automatic clear_mon();
      mon_addr.delete(); mon_data.delete(); mon_cyc.delete();
      n_done = 0; n_crc = 0; n_ferr = 0; n_rise = 0;
      done_cyc = 0; crc_cyc = 0; ferr_cyc = 0; rise_cyc = 0;
   endtask

   // Reference frame and CRC model (CRC-16 0x1021, init 0, bits in line order)
   logic [7:0] frm[$];

   function automatic logic [15:0] crc_model(int n);
      logic [15:0] c;
      logic        fb;
      c = 16'h0000;
      for (int i = 0; i < n; i++)
         for (int k = 0; k < 8; k++) begin
            fb = frm[i][k] ^ c[15];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
         end
      return c;
   endfunction

   task automatic build_frame(input int len, input logic [7:0] b0, input logic [7:0] b1);
      logic [15:0] c;
      frm.delete();
      frm.push_back(b0);
      frm.push_back(b1);
      frm.push_back(8'(len));
      for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
      c = crc_model(len + 3);
      frm.push_back(c[7:0]);
      frm.push_back(c[15:8]);
   endtask

   // Line drivers
   task automatic send_bit(input logic v, input logic [15:0] per);
      rx = v;
      repeat (int'(per) + 1) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop, input logic [15:0] per);
      send_bit(1'b0, per);
      for (int k = 0; k < 8; k++) send_bit(b[k], per);
      send_bit(stop, per);
   endtask

   task automatic send_frame(input int nbytes);
      for (int i = 0; i < nbytes; i++) begin
         send_byte(frm[i], 1'b1, (i == 0) ? period_ls : period_hs);
         repeat ($urandom_range(0, 3)) send_bit(1'b1, period_hs);
      end
      rx = 1'b1;
   endtask

   task automatic check_frame(input string name, input logic expect_done);
      int last;
      total++;
      if (mon_addr.size() !== frm.size()) begin
         bad++;
         $display("FAIL %s wr_count: got %0d want %0d", name, mon_addr.size(), frm.size());
      end
      for (int i = 0; i < frm.size() && i < mon_addr.size(); i++) begin
         total++;
         if (mon_addr[i] !== 8'(i) || mon_data[i] !== frm[i]) begin
            bad++;
            $display("FAIL %s byte%0d: got addr %0h data %0h want addr %0h data %0h",
                     name, i, mon_addr[i], mon_data[i], i, frm[i]);
         end
      end
      total++;
      if (n_done !== int'(expect_done) || n_crc !== int'(!expect_done) || n_ferr !== 0) begin
         bad++;
         $display("FAIL %s pulses: got done=%0d crc_err=%0d frame_err=%0d want done=%0d crc_err=%0d frame_err=0",
                  name, n_done, n_crc, n_ferr, expect_done, !expect_done);
      end
      if (mon_cyc.size() > 0) begin
         last = mon_cyc[mon_cyc.size() - 1];
         total++;
         if ((expect_done ? done_cyc : crc_cyc) !== last + 1) begin
            bad++;
            $display("FAIL %s pulse_latency: got cycle %0d want %0d",
                     name, expect_done ? done_cyc : crc_cyc, last + 1);
         end
      end
   endtask

   // Tests
   task automatic test_reset();
      reset = 1'b1; rx = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({wr_en, frame_done, crc_err, frame_err, tx_permit, bus_idle} !== 6'b000001) begin
         bad++;
         $display("FAIL reset_flags: got %b want 000001",
                  {wr_en, frame_done, crc_err, frame_err, tx_permit, bus_idle});
      end
      total++;
      if (wr_addr !== 8'd0 || wr_data !== 8'd0) begin
         bad++;
         $display("FAIL reset_bus: got addr %0h data %0h want 0 0", wr_addr, wr_data);
      end
      reset = 1'b0;
      repeat (5) @(posedge clk);
   endtask

   task automatic test_spec_frame();
      logic [15:0] c;
      frm.delete();
      frm.push_back(8'h01); frm.push_back(8'h02); frm.push_back(8'h02);
      frm.push_back(8'hAA); frm.push_back(8'h55);
      c = crc_model(5);
      frm.push_back(c[7:0]); frm.push_back(c[15:8]);
      clear_mon();
      send_frame(frm.size());
      repeat (30) @(posedge clk);
      check_frame("spec_frame", 1'b1);
   endtask

   task automatic test_crc_err();
      frm[6] = frm[6] ^ 8'h01;
      clear_mon();
      send_frame(frm.size());
      repeat (30) @(posedge clk);
      check_frame("crc_err", 1'b0);
   endtask

   task automatic test_random_frames();
      int   len;
      logic corrupt;
      for (int it = 0; it < 6; it++) begin
         len     = $urandom_range(0, 8);
         corrupt = ($urandom_range(0, 2) == 0);
         build_frame(len, 8'($urandom), 8'($urandom));
         if (corrupt)
            frm[len + 3 + $urandom_range(0, 1)] ^= 8'(1 << $urandom_range(0, 7));
         clear_mon();
         send_frame(frm.size());
         repeat (30) @(posedge clk);
         check_frame($sformatf("random%0d", it), !corrupt);
      end
   endtask

   task automatic test_stop_err();
      build_frame(2, 8'h3C, 8'hC3);
      clear_mon();
      send_byte(frm[0], 1'b1, period_ls);
      send_byte(frm[1], 1'b0, period_hs);
      rx = 1'b1;
      repeat (30) @(posedge clk);
      total++;
      if (n_ferr !== 1 || mon_addr.size() !== 1 || n_done !== 0 || n_crc !== 0) begin
         bad++;
         $display("FAIL stop_err: got frame_err=%0d writes=%0d done=%0d crc_err=%0d want 1 1 0 0",
                  n_ferr, mon_addr.size(), n_done, n_crc);
      end
      build_frame(3, 8'($urandom), 8'($urandom));
      clear_mon();
      send_frame(frm.size());
      repeat (30) @(posedge clk);
      check_frame("after_stop_err", 1'b1);
   endtask

   task automatic test_idle_timeout();
      int w, want_err, want_rise;
      build_frame(3, 8'h11, 8'h22);
      clear_mon();
      send_frame(3);
      repeat (600) @(posedge clk);
      @(negedge clk);
      total++;
      if (mon_cyc.size() !== 3 || n_ferr !== 1 || n_done !== 0 || n_crc !== 0) begin
         bad++;
         $display("FAIL idle_timeout_counts: got writes=%0d frame_err=%0d done=%0d crc_err=%0d want 3 1 0 0",
                  mon_cyc.size(), n_ferr, n_done, n_crc);
      end
      if (mon_cyc.size() == 3 && n_ferr == 1) begin
         w         = mon_cyc[2];
         want_err  = int'(max_idle_len) * (int'(period_ls) + 1);
         want_rise = int'(tx_permit_len) * (int'(period_ls) + 1);
         total++;
         if (ferr_cyc - w < want_err - 3 || ferr_cyc - w > want_err + 3) begin
            bad++;
            $display("FAIL idle_timeout_delay: got %0d cycles want %0d", ferr_cyc - w, want_err);
         end
         total++;
         if (n_rise !== 1 || rise_cyc - w < want_rise - 3 || rise_cyc - w > want_rise + 3) begin
            bad++;
            $display("FAIL permit_rise: got rises=%0d delay=%0d want 1 %0d", n_rise, rise_cyc - w, want_rise);
         end
      end
   endtask

   task automatic test_glitch();
      int g, want;
      @(negedge clk);
      total++;
      if (tx_permit !== 1'b1) begin
         bad++;
         $display("FAIL glitch_pre_permit: got %b want 1", tx_permit);
      end
      clear_mon();
      rx = 1'b0; g = cyc;
      repeat (8) @(negedge clk);
      total++;
      if (bus_idle !== 1'b0 || tx_permit !== 1'b0) begin
         bad++;
         $display("FAIL glitch_during: got bus_idle=%b tx_permit=%b want 0 0", bus_idle, tx_permit);
      end
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (60) @(negedge clk);
      total++;
      if (bus_idle !== 1'b1 || tx_permit !== 1'b0) begin
         bad++;
         $display("FAIL glitch_after: got bus_idle=%b tx_permit=%b want 1 0", bus_idle, tx_permit);
      end
      repeat (500) @(negedge clk);
      want = int'(tx_permit_len) * (int'(period_ls) + 1) + int'(period_ls) / 2;
      total++;
      if (n_rise !== 1 || rise_cyc - g < want - 15 || rise_cyc - g > want + 20) begin
         bad++;
         $display("FAIL glitch_rerise: got rises=%0d delay=%0d want 1 ~%0d", n_rise, rise_cyc - g, want);
      end
      total++;
      if (mon_cyc.size() !== 0 || n_ferr !== 0 || n_done !== 0 || n_crc !== 0) begin
         bad++;
         $display("FAIL glitch_quiet: got writes=%0d frame_err=%0d done=%0d crc_err=%0d want 0 0 0 0",
                  mon_cyc.size(), n_ferr, n_done, n_crc);
      end
   endtask

   task automatic test_reset_mid();
      int r, want;
      build_frame(4, 8'h5A, 8'hA5);
      clear_mon();
      send_frame(5);
      send_bit(1'b0, period_hs);
      send_bit(frm[5][0], period_hs);
      send_bit(frm[5][1], period_hs);
      send_bit(frm[5][2], period_hs);
      total++;
      if (mon_cyc.size() !== 5) begin
         bad++;
         $display("FAIL reset_mid_prewrites: got %0d want 5", mon_cyc.size());
      end
      @(negedge clk);
      reset = 1'b1; rx = 1'b1;
      @(negedge clk);
      total++;
      if ({wr_en, frame_done, crc_err, frame_err, tx_permit, bus_idle} !== 6'b000001 ||
          wr_addr !== 8'd0 || wr_data !== 8'd0) begin
         bad++;
         $display("FAIL reset_mid_values: got flags %b addr %0h data %0h want 000001 0 0",
                  {wr_en, frame_done, crc_err, frame_err, tx_permit, bus_idle}, wr_addr, wr_data);
      end
      reset = 1'b0; r = cyc;
      clear_mon();
      repeat (300) @(negedge clk);
      total++;
      if (tx_permit !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_permit_early: got %b want 0", tx_permit);
      end
      repeat (300) @(negedge clk);
      want = int'(tx_permit_len) * (int'(period_ls) + 1);
      total++;
      if (n_rise !== 1 || rise_cyc - r < want - 5 || rise_cyc - r > want + 5) begin
         bad++;
         $display("FAIL reset_mid_permit_rise: got rises=%0d delay=%0d want 1 %0d", n_rise, rise_cyc - r, want);
      end
      total++;
      if (mon_cyc.size() !== 0 || n_ferr !== 0 || n_done !== 0 || n_crc !== 0) begin
         bad++;
         $display("FAIL reset_mid_quiet: got writes=%0d frame_err=%0d done=%0d crc_err=%0d want 0 0 0 0",
                  mon_cyc.size(), n_ferr, n_done, n_crc);
      end
   endtask

   initial begin
      period_ls     = 16'd39;
      period_hs     = 16'd9;
      tx_permit_len = 10'd10;
      max_idle_len  = 10'd8;
      clear_mon();
      test_reset();
      test_spec_frame();
      test_crc_err();
      test_random_frames();
      test_stop_err();
      test_idle_timeout();
      test_glitch();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end
endmodule
